// File: rtl/reg_file_pkg.sv
// Shared definitions for the register-file storage blocks: default
// geometry and a helper that turns an address width into an entry count.
`timescale 1ns/1ps
package reg_file_pkg;

  localparam int RF_DEFAULT_DATA_WIDTH = 32;
  localparam int RF_DEFAULT_ADDR_WIDTH = 5;

  // Number of entries addressed by an addr_width-bit pointer.
  function automatic int rf_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/reg_file_1port.sv
// reg_file_1port: 2**addr_width x data_width register file with one
// synchronous write port and one combinational read port. Intended as the
// backing store of circular FIFOs: write at the tail pointer, read at the
// head pointer, and the dequeued data is available in the same cycle.
//
// Optional feature macro REG_FILE_1PORT_WR_BYPASS_EN:
//   defined   - a write to the entry being read is forwarded to D_OUT in
//               the same cycle (write-through), except while in reset.
//   undefined - D_OUT always shows stored contents, so a read-during-write
//               to the same entry returns the old data until the edge.
`timescale 1ns/1ps
module reg_file_1port
  import reg_file_pkg::*;
#(
  parameter int data_width = RF_DEFAULT_DATA_WIDTH,
  parameter int addr_width = RF_DEFAULT_ADDR_WIDTH
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic [addr_width-1:0] ADDR_IN,
  input  logic [addr_width-1:0] ADDR_OUT,
  input  logic [data_width-1:0] D_IN,
  input  logic                  WE,
  output logic [data_width-1:0] D_OUT
);

  localparam int Depth = rf_depth(addr_width);

  logic [data_width-1:0] mem_q [Depth];
  logic [data_width-1:0] mem_d [Depth];
  logic [data_width-1:0] rd_data;

  // Next-state of the array: only the addressed entry changes, and only on WE.
  always_comb begin
    mem_d = mem_q;
    if (WE) begin
      mem_d[ADDR_IN] = D_IN;
    end
  end

  // Storage; reset clears every entry immediately and overrides any write.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Zero-latency read mux; every address is in range so no bounds logic.
  always_comb begin
    rd_data = mem_q[ADDR_OUT];
  end

`ifdef REG_FILE_1PORT_WR_BYPASS_EN
  // Write-through: same-entry write data reaches D_OUT before the edge.
  always_comb begin
    D_OUT = rd_data;
    if (rst_n && WE && (ADDR_IN == ADDR_OUT)) begin
      D_OUT = D_IN;
    end
  end
`else
  // Old-data read-during-write: D_OUT only ever shows stored contents.
  always_comb begin
    D_OUT = rd_data;
  end
`endif

endmodule

// File: tb/tb_reg_file_1port.sv
// Directed bench for reg_file_1port: a 8x132 instance exercises reset,
// sweep, read-during-write, FIFO wrap and reset-vs-write; a 2x1 instance
// checks the narrowest geometry.
`timescale 1ns/1ps
module tb_reg_file_1port;

  localparam int DW = 132;
  localparam int AW = 3;

  // ---------------- clock / reset ----------------
  logic CLK;
  logic clk_run;
  logic rst_n;

  initial begin
    CLK = 1'b0;
    forever begin
      #5;
      if (clk_run) CLK = ~CLK;
    end
  end

  // ---------------- main instance (8 x 132) ----------------
  logic [AW-1:0] addr_in, addr_out;
  logic [DW-1:0] d_in, d_out;
  logic          we;

  reg_file_1port #(.data_width(DW), .addr_width(AW)) dut (
    .CLK     (CLK),
    .rst_n   (rst_n),
    .ADDR_IN (addr_in),
    .ADDR_OUT(addr_out),
    .D_IN    (d_in),
    .WE      (we),
    .D_OUT   (d_out)
  );

  // ---------------- narrow instance (2 x 1) ----------------
  logic [0:0] n_addr_in, n_addr_out;
  logic [0:0] n_d_in, n_d_out;
  logic       n_we;

  reg_file_1port #(.data_width(1), .addr_width(1)) dut_n (
    .CLK     (CLK),
    .rst_n   (rst_n),
    .ADDR_IN (n_addr_in),
    .ADDR_OUT(n_addr_out),
    .D_IN    (n_d_in),
    .WE      (n_we),
    .D_OUT   (n_d_out)
  );

  int n_checks;
  int n_fail;

  // ---------------- expected-value helpers ----------------
  function automatic logic [DW-1:0] sweep_val(input int a);
    logic [31:0] w;
    w = 32'(a) * 32'h11111111;
    return {4'hA, w, w, w, w};
  endfunction

  function automatic logic [DW-1:0] fifo_val(input int i);
    logic [31:0] w;
    w = 32'hF000_0000 | 32'(i + 1);
    return {4'h5, w, ~w, w, 32'(i) * 32'h0101_0101};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic write_entry(input logic [AW-1:0] a, input logic [DW-1:0] v);
    @(negedge CLK);
    we = 1'b1; addr_in = a; d_in = v;
    @(posedge CLK);
    #1;
    we = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      we = 1'b0;
      addr_in = AW'($urandom_range(0, 7));
      d_in = {$urandom, $urandom, $urandom, $urandom, 4'($urandom)};
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [DW-1:0] zero;
    zero = '0;
    // Fill entries, then stop the clock and pull reset: contents must vanish without an edge.
    for (int a = 0; a < 8; a++) write_entry(AW'(a), sweep_val(a) | 132'h1);
    @(negedge CLK);
    clk_run = 1'b0;
    #2;
    rst_n = 1'b0;
    for (int a = 0; a < 8; a++) begin
      addr_out = AW'(a);
      #1;
      n_checks++;
      if (d_out !== zero) begin
        n_fail++;
        $display("FAIL reset_no_edge addr=%0d: got %h expected %h", a, d_out, zero);
      end
    end
    #2;
    rst_n = 1'b1;
    clk_run = 1'b1;
    idle_cycles(3);
    for (int a = 0; a < 8; a++) begin
      addr_out = AW'(a);
      #1;
      n_checks++;
      if (d_out !== zero) begin
        n_fail++;
        $display("FAIL reset_after_release addr=%0d: got %h expected %h", a, d_out, zero);
      end
    end
  endtask

  task automatic test_sweep;
    for (int a = 0; a < 8; a++) write_entry(AW'(a), sweep_val(a));
    @(negedge CLK);
    for (int a = 7; a >= 0; a--) begin
      addr_out = AW'(a);
      #1;
      n_checks++;
      if (d_out !== sweep_val(a)) begin
        n_fail++;
        $display("FAIL sweep addr=%0d: got %h expected %h", a, d_out, sweep_val(a));
      end
    end
    // WE=0 with garbage address/data must leave everything untouched.
    idle_cycles(6);
    @(negedge CLK);
    for (int a = 0; a < 8; a++) begin
      addr_out = AW'(a);
      #1;
      n_checks++;
      if (d_out !== sweep_val(a)) begin
        n_fail++;
        $display("FAIL sweep_we0 addr=%0d: got %h expected %h", a, d_out, sweep_val(a));
      end
    end
  endtask

  task automatic test_read_during_write;
    logic [DW-1:0] old_v, new_v, exp_before;
    old_v = 132'd5;
    new_v = 132'd9;
    write_entry(3'd3, old_v);
    @(negedge CLK);
    we = 1'b1; addr_in = 3'd3; addr_out = 3'd3; d_in = new_v;
    #1;
`ifdef REG_FILE_1PORT_WR_BYPASS_EN
    exp_before = new_v;
`else
    exp_before = old_v;
`endif
    n_checks++;
    if (d_out !== exp_before) begin
      n_fail++;
      $display("FAIL rdw_before_edge: got %h expected %h", d_out, exp_before);
    end
    @(posedge CLK);
    #1;
    we = 1'b0;
    #1;
    n_checks++;
    if (d_out !== new_v) begin
      n_fail++;
      $display("FAIL rdw_after_edge: got %h expected %h", d_out, new_v);
    end
  endtask

  task automatic test_fifo_wrap;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_v;
    // Prime: enqueue item 0 at tail 0.
    write_entry(3'd0, fifo_val(0));
    exp_q.push_back(fifo_val(0));
    // Each cycle enqueue item k at tail k%8 while dequeuing the head.
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      we = 1'b1; addr_in = AW'(k % 8); d_in = fifo_val(k);
      addr_out = AW'(k - 1);
      #1;
      if (k == 8) begin
        // Entry 0 is being overwritten: it must still hold item 0 before the edge.
        addr_out = 3'd0;
        #1;
        n_checks++;
        if (d_out !== fifo_val(0)) begin
          n_fail++;
          $display("FAIL fifo_overwrite_before_edge: got %h expected %h", d_out, fifo_val(0));
        end
        addr_out = 3'd7;
        #1;
      end
      exp_v = exp_q.pop_front();
      n_checks++;
      if (d_out !== exp_v) begin
        n_fail++;
        $display("FAIL fifo_dequeue k=%0d: got %h expected %h", k, d_out, exp_v);
      end
      exp_q.push_back(fifo_val(k));
      @(posedge CLK);
      #1;
      we = 1'b0;
    end
    @(negedge CLK);
    addr_out = 3'd0;
    #1;
    exp_v = exp_q.pop_front();
    n_checks++;
    if (d_out !== exp_v) begin
      n_fail++;
      $display("FAIL fifo_wrap_head0: got %h expected %h", d_out, exp_v);
    end
  endtask

  task automatic test_reset_with_write;
    logic [DW-1:0] zero;
    zero = '0;
    write_entry(3'd2, sweep_val(2) | 132'h7);
    @(negedge CLK);
    we = 1'b1; addr_in = 3'd2; addr_out = 3'd2; d_in = fifo_val(42);
    #4;
    rst_n = 1'b0;
    @(posedge CLK);
    #1;
    n_checks++;
    if (d_out !== zero) begin
      n_fail++;
      $display("FAIL reset_vs_write_in_reset: got %h expected %h", d_out, zero);
    end
    @(negedge CLK);
    we = 1'b0;
    rst_n = 1'b1;
    @(posedge CLK);
    #1;
    n_checks++;
    if (d_out !== zero) begin
      n_fail++;
      $display("FAIL reset_vs_write_after_release: got %h expected %h", d_out, zero);
    end
  endtask

  task automatic test_narrow;
    logic [0:0] pat [2][2];
    pat[0][0] = 1'b1; pat[0][1] = 1'b0;
    pat[1][0] = 1'b0; pat[1][1] = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int a = 0; a < 2; a++) begin
        @(negedge CLK);
        n_we = 1'b1; n_addr_in = 1'(a); n_d_in = pat[r][a];
        @(posedge CLK);
        #1;
        n_we = 1'b0;
      end
      @(negedge CLK);
      for (int a = 0; a < 2; a++) begin
        n_addr_out = 1'(a);
        #1;
        n_checks++;
        if (n_d_out !== pat[r][a]) begin
          n_fail++;
          $display("FAIL narrow round=%0d addr=%0d: got %b expected %b", r, a, n_d_out, pat[r][a]);
        end
      end
    end
  endtask

  // ---------------- sequencer and final report ----------------
  initial begin
    n_checks = 0;
    n_fail = 0;
    clk_run = 1'b1;
    rst_n = 1'b0;
    we = 1'b0; addr_in = '0; addr_out = '0; d_in = '0;
    n_we = 1'b0; n_addr_in = '0; n_addr_out = '0; n_d_in = '0;
    #1;
    n_checks++;
    if (d_out !== '0) begin
      n_fail++;
      $display("FAIL power_on_reset: got %h expected 0", d_out);
    end
    #12;
    rst_n = 1'b1;
    test_reset();
    test_sweep();
    test_read_during_write();
    test_fifo_wrap();
    test_reset_with_write();
    test_narrow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
